operand_bypass_reg: RTL

- Sits between the forwarding comparator and the execute stage, on the ID/EX boundary.
- Uses the comparator's per-operand match flags to pick each execute operand from three sources: register-file read data, the EX-stage result or the MEM-stage result.
- Registers the chosen operands into EX.
- Detects load-use hazards, stalls decode for one cycle and inserts a bubble.

---
 rtl/operand_bypass_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/operand_bypass_reg.sv
// ============================================================================
// operand_bypass_reg : ID/EX operand bypass mux, load-use stall, EX registers
// Rev 1.0
// ============================================================================
`default_nettype none

module operand_bypass_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_id,
  input  logic             useRn,
  input  logic             useRmd,
  input  logic [WIDTH-1:0] rdataRn,
  input  logic [WIDTH-1:0] rdataRmd,
  input  logic             flag1Rn,
  input  logic             flag1Rmd,
  input  logic             flag2Rn,
  input  logic             flag2Rmd,
  input  logic             prevIsLoad,
  input  logic [WIDTH-1:0] exResult,
  input  logic [WIDTH-1:0] memResult,
  input  logic             flush,
  output logic             stall,
  output logic [WIDTH-1:0] opA_ex,
  output logic [WIDTH-1:0] opB_ex,
  output logic             valid_ex
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_LOADWAIT = 1'b1;

  logic [0:0]       r_state;
  logic             r_pend_rn;
  logic             r_pend_rmd;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_valid;

  logic             w_dep_rn;
  logic             w_dep_rmd;
  logic             w_hazard;
  logic [WIDTH-1:0] w_norm_a;
  logic [WIDTH-1:0] w_norm_b;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  assign w_dep_rn  = useRn & flag1Rn;
  assign w_dep_rmd = useRmd & flag1Rmd;
  assign w_hazard  = valid_id & prevIsLoad & (w_dep_rn | w_dep_rmd);

  // Newest producer wins: EX result over MEM result over register file.
  always_comb begin
    w_norm_a = rdataRn;
    if (useRn) begin
      if (flag1Rn)      w_norm_a = exResult;
      else if (flag2Rn) w_norm_a = memResult;
    end
    w_norm_b = rdataRmd;
    if (useRmd) begin
      if (flag1Rmd)      w_norm_b = exResult;
      else if (flag2Rmd) w_norm_b = memResult;
    end
  end

  // After the bubble the load has moved to MEM, so its data sits on memResult.
  always_comb begin
    w_sel_a = w_norm_a;
    w_sel_b = w_norm_b;
    if (r_state == ST_LOADWAIT) begin
      if (r_pend_rn)  w_sel_a = memResult;
      if (r_pend_rmd) w_sel_b = memResult;
    end
  end

  assign stall = reset & (r_state == ST_RUN) & w_hazard & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_pend_rn  <= 1'b0;
      r_pend_rmd <= 1'b0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_valid    <= 1'b0;
    end else if (flush) begin
      r_state    <= ST_RUN;
      r_pend_rn  <= 1'b0;
      r_pend_rmd <= 1'b0;
      r_valid    <= 1'b0;
    end else if (r_state == ST_RUN && w_hazard) begin
      r_state    <= ST_LOADWAIT;
      r_pend_rn  <= w_dep_rn;
      r_pend_rmd <= w_dep_rmd;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= ST_RUN;
      r_pend_rn  <= 1'b0;
      r_pend_rmd <= 1'b0;
      r_opa      <= w_sel_a;
      r_opb      <= w_sel_b;
      r_valid    <= valid_id;
    end
  end

  assign opA_ex   = r_opa;
  assign opB_ex   = r_opb;
  assign valid_ex = r_valid;

endmodule

`default_nettype wire
